// File: rtl/adc_read_arbiter.sv
// +--------------------------------------------------------------------------+
// | adc_read_arbiter: round-robin sharing of the ADC scanner readout port     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module adc_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [4*NUM_REQ-1:0] REQ_CH,
  output logic [NUM_REQ-1:0]   GNT,
  output logic [NUM_REQ-1:0]   ACK,
  output logic                 ERR,
  output logic [11:0]          DATA_OUT,
  output logic                 ADC_Read,
  output logic [3:0]           ADC_Channel,
  input  logic [11:0]          ADC_Result,
  input  logic                 ADC_RDY
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] C_TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] C_PTR_RESET  = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic [11:0]          data_q, data_d;
  logic                 adc_read_q, adc_read_d;
  logic [3:0]           adc_ch_q, adc_ch_d;

  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [3:0]           win_ch;

  // Search starts just above the last winner so it ranks lowest next time.
  always_comb begin
    int            cand_int;
    logic [IW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    win_ch    = '0;
    cand_int  = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_int = int'(rr_ptr_q) + k;
      if (cand_int >= NUM_REQ) begin
        cand_int = cand_int - NUM_REQ;
      end
      cand = IW'(cand_int);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_ch    = REQ_CH[{cand, 2'b00} +: 4];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    err_d      = err_q;
    data_d     = data_q;
    adc_read_d = adc_read_q;
    adc_ch_d   = adc_ch_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          adc_ch_d       = win_ch;
          adc_read_d     = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (ADC_RDY || (timer_q == C_TIMER_LAST)) begin
          // A result arriving on the timeout cycle still counts as success.
          data_d       = ADC_RDY ? ADC_Result : 12'd0;
          err_d        = !ADC_RDY;
          adc_read_d   = 1'b0;
          gnt_d        = '0;
          ack_d[idx_q] = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        err_d    = 1'b0;
        rr_ptr_d = idx_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= C_PTR_RESET;
      idx_q      <= '0;
      timer_q    <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      adc_read_q <= 1'b0;
      adc_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      data_q     <= data_d;
      adc_read_q <= adc_read_d;
      adc_ch_q   <= adc_ch_d;
    end
  end

  assign GNT         = gnt_q;
  assign ACK         = ack_q;
  assign ERR         = err_q;
  assign DATA_OUT    = data_q;
  assign ADC_Read    = adc_read_q;
  assign ADC_Channel = adc_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_read_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_adc_read_arbiter: directed scoreboard bench for adc_read_arbiter       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_adc_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;
  localparam int M_FAST  = 0;
  localparam int M_NEVER = 1;
  localparam int M_DLY   = 2;

  logic                 CLK = 1'b0;
  logic                 RSTn = 1'b0;
  logic [NUM_REQ-1:0]   REQ = '0;
  logic [4*NUM_REQ-1:0] REQ_CH = '0;
  logic [NUM_REQ-1:0]   GNT;
  logic [NUM_REQ-1:0]   ACK;
  logic                 ERR;
  logic [11:0]          DATA_OUT;
  logic                 ADC_Read;
  logic [3:0]           ADC_Channel;
  logic [11:0]          ADC_Result = '0;
  logic                 ADC_RDY = 1'b0;

  always #5 CLK = ~CLK;

  adc_read_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .REQ_CH(REQ_CH),
    .GNT(GNT), .ACK(ACK), .ERR(ERR), .DATA_OUT(DATA_OUT),
    .ADC_Read(ADC_Read), .ADC_Channel(ADC_Channel),
    .ADC_Result(ADC_Result), .ADC_RDY(ADC_RDY)
  );

  typedef struct packed {
    logic [3:0]  ack;
    logic        err;
    logic [11:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mode = M_FAST;
  int   rcnt = 0;
  int   lo_run = 0;
  logic prev_rd = 1'b0;
  bit   gap_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic e, input logic [11:0] d);
    exp_t x;
    x.ack = a; x.err = e; x.data = d;
    sb.push_back(x);
  endtask

  function automatic logic [11:0] model_val(input logic [3:0] ch);
    return {4'hA, ch, 4'hC};
  endfunction

  // Scanner model: counts cycles Read has been high, answers by mode.
  always @(negedge CLK) begin
    rcnt = ADC_Read ? rcnt + 1 : 0;
    case (mode)
      M_FAST: begin
        ADC_RDY    = (rcnt >= 2);
        ADC_Result = ADC_RDY ? model_val(ADC_Channel) : 12'hEEE;
      end
      M_DLY: begin
        ADC_RDY    = (rcnt >= 5);
        ADC_Result = ADC_RDY ? 12'h123 : 12'hEEE;
      end
      default: begin
        ADC_RDY    = 1'b0;
        ADC_Result = 12'hEEE;
      end
    endcase
  end

  // Monitor: pops the scoreboard on every ACK and tracks Read low gaps.
  always @(negedge CLK) begin
    exp_t e;
    if (ACK != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ACK), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_vec", 32'(ACK), 32'(e.ack));
        chk("ack_err", 32'(ERR), 32'(e.err));
        chk("ack_data", 32'(DATA_OUT), 32'(e.data));
      end
    end
    if (ADC_Read && !prev_rd && gap_en) begin
      chk("read_gap_ge2", 32'(lo_run >= 2), 32'd1);
    end
    lo_run  = ADC_Read ? 0 : lo_run + 1;
    prev_rd = ADC_Read;
  end

  task automatic wait_ack(input int start, input int limit, output int n);
    n = start;
    do begin
      @(negedge CLK);
      n++;
    end while (ACK == '0 && n < limit);
    if (ACK == '0) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gnt"}, 32'(GNT), 32'd0);
    chk({tag, "_ack"}, 32'(ACK), 32'd0);
    chk({tag, "_err"}, 32'(ERR), 32'd0);
    chk({tag, "_data"}, 32'(DATA_OUT), 32'd0);
    chk({tag, "_read"}, 32'(ADC_Read), 32'd0);
    chk({tag, "_chan"}, 32'(ADC_Channel), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw_gnt2;
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    chk_outputs_zero("reset");
    RSTn = 1'b1;
    @(negedge CLK);

    // 1: single request, best-case latency
    REQ_CH[3:0] = 4'd5;
    REQ = 4'b0001;
    push(4'b0001, 1'b0, 12'hA5C);
    @(negedge CLK);
    chk("t1_gnt", 32'(GNT), 32'h1);
    chk("t1_read", 32'(ADC_Read), 32'd1);
    chk("t1_chan", 32'(ADC_Channel), 32'd5);
    wait_ack(1, 10, n);
    chk("t1_latency", 32'(n), 32'd3);
    REQ = '0;
    @(negedge CLK);

    // 2: all requesters held, fresh pointer -> 0,1,2,3,0
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    REQ_CH = {4'd4, 4'd3, 4'd2, 4'd1};
    gap_en = 1'b1;
    push(4'b0001, 1'b0, model_val(4'd1));
    push(4'b0010, 1'b0, model_val(4'd2));
    push(4'b0100, 1'b0, model_val(4'd3));
    push(4'b1000, 1'b0, model_val(4'd4));
    push(4'b0001, 1'b0, model_val(4'd1));
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(0, 20, n);
    end
    REQ = '0;
    @(negedge CLK);
    gap_en = 1'b0;

    // 3: scanner never ready -> timeout, then a normal request
    mode = M_NEVER;
    REQ_CH[7:4] = 4'd7;
    REQ = 4'b0010;
    push(4'b0010, 1'b1, 12'h000);
    wait_ack(0, TIMEOUT + 20, n);
    chk("t3_timeout_latency", 32'(n), 32'(TIMEOUT + 2));
    REQ = '0;
    mode = M_FAST;
    @(negedge CLK);
    chk("t3_err_clear", 32'(ERR), 32'd0);
    chk("t3_ack_clear", 32'(ACK), 32'd0);
    REQ_CH[11:8] = 4'd6;
    REQ = 4'b0100;
    push(4'b0100, 1'b0, model_val(4'd6));
    wait_ack(0, 20, n);
    chk("t3_next_latency", 32'(n), 32'd3);
    REQ = '0;
    @(negedge CLK);

    // 4: busy scanner; channel change during WAIT ignored
    mode = M_DLY;
    REQ_CH[15:12] = 4'd2;
    REQ = 4'b1000;
    push(4'b1000, 1'b0, 12'h123);
    repeat (2) @(negedge CLK);
    REQ_CH[15:12] = 4'd9;
    @(negedge CLK);
    chk("t4_chan_hold", 32'(ADC_Channel), 32'd2);
    wait_ack(3, 20, n);
    chk("t4_latency", 32'(n), 32'd6);
    REQ = '0;
    @(negedge CLK);

    // 5: reset during WAIT, then all request -> requester 0 first
    mode = M_NEVER;
    REQ_CH = {4'd4, 4'd3, 4'd2, 4'd1};
    REQ = 4'b0001;
    repeat (4) @(negedge CLK);
    RSTn = 1'b0;
    REQ = 4'b1111;
    @(negedge CLK);
    chk_outputs_zero("t5_midreset");
    RSTn = 1'b1;
    mode = M_FAST;
    push(4'b0001, 1'b0, model_val(4'd1));
    @(negedge CLK);
    chk("t5_first_gnt", 32'(GNT), 32'h1);
    wait_ack(1, 20, n);
    chk("t5_latency", 32'(n), 32'd3);
    REQ = '0;
    @(negedge CLK);

    // 6: requester 2 drops REQ during WAIT
    mode = M_DLY;
    REQ_CH[11:8] = 4'd3;
    REQ_CH[3:0]  = 4'd1;
    REQ = 4'b0101;
    push(4'b0100, 1'b0, 12'h123);
    push(4'b0001, 1'b0, 12'h123);
    repeat (2) @(negedge CLK);
    chk("t6_gnt2", 32'(GNT), 32'h4);
    REQ = 4'b0001;
    wait_ack(2, 20, n);
    saw_gnt2 = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      saw_gnt2 |= GNT[2];
    end
    wait_ack(3, 20, n);
    REQ = '0;
    repeat (10) begin
      @(negedge CLK);
      saw_gnt2 |= GNT[2];
    end
    chk("t6_no_regrant2", 32'(saw_gnt2), 32'd0);
    chk("t6_idle_gnt", 32'(GNT), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
